// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Each serial bit lasts 'prescale' clocks; all outputs are registered.
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] P_DATA,
    input  logic       DATA_VALID,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    input  logic [5:0] prescale,
    output logic       TX_OUT,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    state_t     w_state_n;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_n;
    logic [5:0] r_pre;
    logic [2:0] r_idx;
    logic [2:0] w_idx_n;
    logic [7:0] r_data;
    logic       r_par_en;
    logic       r_par_typ;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;
    logic       w_accept;
    logic       w_last;
    logic       w_par;
    logic       w_tx_n;
    logic       w_busy_n;
    logic       w_done_n;

    assign w_last   = (r_cnt == r_pre - 6'd1);
    assign w_accept = (r_state == S_IDLE) && DATA_VALID && (prescale >= 6'd2);
    // Odd parity is the inverse of even parity.
    assign w_par    = (^r_data) ^ r_par_typ;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_n = S_START;
                    w_cnt_n   = 6'd0;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_state_n = S_DATA;
                    w_cnt_n   = 6'd0;
                    w_idx_n   = 3'd0;
                end else begin
                    w_cnt_n = r_cnt + 6'd1;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_cnt_n = 6'd0;
                    if (r_idx == 3'd7) begin
                        w_state_n = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_n = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt + 6'd1;
                end
            end
            S_PARITY: begin
                if (w_last) begin
                    w_state_n = S_STOP;
                    w_cnt_n   = 6'd0;
                end else begin
                    w_cnt_n = r_cnt + 6'd1;
                end
            end
            S_STOP: begin
                if (w_last) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = 6'd0;
                end else begin
                    w_cnt_n = r_cnt + 6'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = 6'd0;
                w_idx_n   = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        w_tx_n = 1'b1;
        case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = r_data[w_idx_n];
            S_PARITY: w_tx_n = w_par;
            default:  w_tx_n = 1'b1;
        endcase
        w_busy_n = (w_state_n != S_IDLE);
        w_done_n = (w_state_n == S_STOP) && (w_cnt_n == r_pre - 6'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_idx     <= 3'd0;
            r_pre     <= 6'd0;
            r_data    <= 8'd0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            if (w_accept) begin
                r_data    <= P_DATA;
                r_par_en  <= PAR_EN;
                r_par_typ <= PAR_TYP;
                r_pre     <= prescale;
            end
        end
    end

    assign TX_OUT  = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random and directed frames, scoreboard queue of
// expected frames, line monitor rebuilding each frame from plain rules.
module tb_uart_tx;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       pt;
        int         p;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    exp_t expq[$];
    logic cap[$];
    int   done_pos[$];
    bit   in_frame = 0;
    bit   aborted  = 0;
    bit   mon_en   = 0;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic end_frame();
        exp_t e;
        logic m[$];
        int   nbits;
        int   bad;
        logic v;
        if (aborted) begin
            checks++;
            if (done_pos.size() != 0) begin
                errors++;
                $display("FAIL abort_done: tx_done seen %0d times, required 0",
                         done_pos.size());
            end
            return;
        end
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got %0d-cycle frame, required none",
                     cap.size());
            return;
        end
        e = expq.pop_front();
        nbits = e.pe ? 11 : 10;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)
                v = 1'b0;
            else if (b <= 8)
                v = e.d[b-1];
            else if (e.pe && b == 9)
                v = 1'(($countones(e.d) + int'(e.pt)) % 2);
            else
                v = 1'b1;
            for (int c = 0; c < e.p; c++) m.push_back(v);
        end
        checks++;
        if (cap.size() != m.size()) begin
            errors++;
            $display("FAIL frame_len d=%h p=%0d pe=%0d: got %0d cycles, required %0d",
                     e.d, e.p, e.pe, cap.size(), m.size());
        end
        checks++;
        bad = -1;
        for (int i = 0; i < m.size() && i < cap.size(); i++)
            if (bad < 0 && cap[i] !== m[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            $display("FAIL frame_bits d=%h p=%0d pe=%0d pt=%0d: cycle %0d got %b, required %b",
                     e.d, e.p, e.pe, e.pt, bad, cap[bad], m[bad]);
        end
        checks++;
        if (done_pos.size() != 1 || done_pos[0] != m.size() - 1) begin
            errors++;
            $display("FAIL tx_done d=%h: got %0d pulses first at %0d, required 1 at %0d",
                     e.d, done_pos.size(),
                     (done_pos.size() > 0) ? done_pos[0] : -1, m.size() - 1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1) begin
                if (!in_frame) begin
                    cap.delete();
                    done_pos.delete();
                    aborted  = 0;
                    in_frame = 1;
                end
                cap.push_back(TX_OUT);
                if (tx_done === 1'b1) done_pos.push_back(cap.size() - 1);
                if (rst === 1'b1) aborted = 1;
            end else begin
                if (in_frame) begin
                    in_frame = 0;
                    end_frame();
                end
                checks++;
                if (TX_OUT !== 1'b1 || tx_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_line: TX_OUT=%b tx_done=%b, required 1/0",
                             TX_OUT, tx_done);
                end
            end
        end
    end

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: busy=%b after %0d cycles, required 1", tag, busy, n);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 11 * 64 + 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input int p);
        exp_t e;
        @(posedge clk); #1;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = 6'(p);
        DATA_VALID = 1'b1;
        e.d = d; e.pe = pe; e.pt = pt; e.p = p;
        expq.push_back(e);
        wait_busy("send");
        DATA_VALID = 1'b0;
        P_DATA     = 8'($urandom);
        PAR_EN     = 1'($urandom);
        PAR_TYP    = 1'($urandom);
        prescale   = 6'($urandom);
        wait_idle("send");
    endtask

    task automatic no_accept(input logic [5:0] p);
        int nb = 0;
        int nl = 0;
        @(posedge clk); #1;
        prescale   = p;
        P_DATA     = 8'h3C;
        DATA_VALID = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) nb++;
            if (TX_OUT !== 1'b1) nl++;
        end
        DATA_VALID = 1'b0;
        checks++;
        if (nb != 0 || nl != 0) begin
            errors++;
            $display("FAIL low_prescale p=%0d: busy cycles %0d low cycles %0d, required 0/0",
                     p, nb, nl);
        end
    endtask

    initial begin
        exp_t e;
        int   g;
        int   n;
        rst = 1'b1;
        P_DATA = 8'h00; DATA_VALID = 1'b0;
        PAR_EN = 1'b0;  PAR_TYP = 1'b0; prescale = 6'd8;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: TX_OUT=%b busy=%b tx_done=%b, required 1/0/0",
                     TX_OUT, busy, tx_done);
        end
        mon_en = 1;

        send(8'hA5, 1'b0, 1'b0, 8);
        send(8'h07, 1'b1, 1'b0, 16);
        send(8'h03, 1'b1, 1'b1, 16);
        send(8'h01, 1'b1, 1'b1, 16);
        send(8'hFF, 1'b1, 1'b0, 2);
        send(8'h5A, 1'b1, 1'b1, 63);

        // Held request: second byte must wait for busy to drop.
        @(posedge clk); #1;
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8;
        DATA_VALID = 1'b1;
        e.d = 8'h55; e.pe = 1'b0; e.pt = 1'b0; e.p = 8;
        expq.push_back(e);
        wait_busy("b2b0");
        P_DATA = 8'hAA;
        e.d = 8'hAA;
        expq.push_back(e);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        g = 0;
        while (busy !== 1'b1 && g < 10) begin
            @(posedge clk); #1;
            g++;
        end
        checks++;
        if (g != 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d idle cycles, required 1", g);
        end
        DATA_VALID = 1'b0;
        wait_idle("b2b1");

        // Reset during data bit 3 of a P=32 frame.
        @(posedge clk); #1;
        P_DATA = 8'($urandom); PAR_EN = 1'b1; prescale = 6'd32;
        DATA_VALID = 1'b1;
        wait_busy("rstf");
        DATA_VALID = 1'b0;
        repeat (4 * 32 + 10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: TX_OUT=%b busy=%b, required 1/0", TX_OUT, busy);
        end

        // Reset wins over a simultaneous request.
        @(posedge clk); #1;
        rst = 1'b1; DATA_VALID = 1'b1; prescale = 6'd8;
        @(posedge clk); #1;
        rst = 1'b0; DATA_VALID = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: busy=%b, required 0", busy);
        end

        send(8'hC3, 1'b0, 1'b0, 8);
        no_accept(6'd1);
        no_accept(6'd0);

        for (int i = 0; i < 20; i++)
            send(8'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(2, 20)));

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_frames: %0d frames never seen, required 0",
                     expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003 P_DATA  input  8  byte to transmit; sampled only on the acceptance edge.
REQ-004 DATA_VALID  input  1  transmit request; accepted only while busy==0.
REQ-005 PAR_EN  input  1  1 = parity bit inserted between data and stop.
REQ-006 PAR_TYP  input  1  0 = even parity, 1 = odd parity; ignored when PAR_EN==0.
REQ-007 prescale  input  6  clk cycles per serial bit; same value the downstream receiver uses (8/16/32 nominal).
REQ-008 TX_OUT  output  1  serial line, idle high, LSB first; feeds receiver RX_IN.
REQ-009 busy  output  1  high for every cycle a frame bit is being driven.
REQ-010 tx_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Function
REQ-011 FSM states: IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-012 Acceptance: IDLE and DATA_VALID==1 and prescale>=2 at rising edge T -> latch P_DATA, PAR_EN, PAR_TYP, prescale; go to START.
REQ-013 Request with prescale 0 or 1 ignored; FSM stays in IDLE, TX_OUT stays 1.
REQ-014 Input changes after T have no effect on the frame in progress.
REQ-015 START: TX_OUT=0 for exactly P cycles (P = latched prescale), cycles T+1..T+P.
REQ-016 DATA: 8 bits, data[0] first, each held for exactly P cycles; 3-bit bit index, 6-bit per-bit cycle counter counting 0..P-1.
REQ-017 PARITY (only when latched PAR_EN==1): one bit for P cycles; value ^data when even, ~^data when odd.
REQ-018 STOP: TX_OUT=1 for P cycles; tx_done=1 in its final cycle only; next state IDLE.
REQ-019 Frame length: 10*P cycles when PAR_EN==0, 11*P cycles when PAR_EN==1; busy=1 for exactly those cycles.
REQ-020 IDLE: TX_OUT=1, busy=0, tx_done=0.
REQ-021 DATA_VALID while busy==1 is ignored and not queued; the producer holds it until busy==0.
REQ-022 Back-to-back: request accepted on the first IDLE cycle after STOP; minimum inter-frame gap is one idle-high cycle.
REQ-023 Cycle counter is wide enough for P=63 without wrap; bit transitions occur only on counter==P-1.

Reset
REQ-024 rst==1 at an edge -> next cycle state IDLE, TX_OUT=1, busy=0, tx_done=0, counters and latched data zeroed.
REQ-025 rst mid-frame abandons the frame and returns the line high on the next cycle; no tx_done for the abandoned frame.
REQ-026 rst takes priority over a simultaneous DATA_VALID; that request is not accepted.

Verification
REQ-027 P=8, PAR_EN=0, P_DATA=0xA5 -> TX_OUT low for 8 cycles, then 1,0,1,0,0,1,0,1 at 8 cycles each, stop high for 8; busy high 80 cycles; tx_done at cycle 80.
REQ-028 P=16, PAR_EN=1, PAR_TYP=0, P_DATA=0x07 -> parity bit 1; frame 176 cycles; receiver sees par_err=0, stp_err=0, data 0x07.
REQ-029 P=16, PAR_EN=1, PAR_TYP=1, P_DATA=0x03 -> parity bit 1; P_DATA=0x01 -> parity bit 0.
REQ-030 DATA_VALID held high with 0x55 then 0xAA, P=8, no parity -> two frames of 80 cycles, separated by exactly one idle cycle; 0xAA is accepted only after busy falls.
REQ-031 rst pulsed during data bit 3 of a P=32 frame -> TX_OUT=1 and busy=0 on the next cycle; no tx_done; a new frame is accepted on the following request.
REQ-032 prescale=1 with DATA_VALID=1 -> no acceptance, busy stays 0, TX_OUT stays 1.
